layer_output_packer: RTL and testbench

- Upstream neighbour of the argmax stage. Collects the output layer's neuron results, which arrive one word at a time over a valid/ready stream.
- Once all numInput words are in, presents them as one packed vector with a single-cycle valid pulse.
- Holds off new input until the downstream argmax stage signals that it has finished. This prevents a new vector from overrunning a search that is still in progress.

---
 rtl/layer_output_packer.sv | 116 +++++++++++
 tb/tb_layer_output_packer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_output_packer.sv
// layer_output_packer
// Collects numInput neuron words from a valid/ready stream into a staging
// buffer, publishes them as one packed vector with a one-cycle valid pulse,
// then holds off new input until the downstream argmax stage reports done.
// Optional build macro PACKER_RELU_EN: negative (MSB set) words are stored as 0.
module layer_output_packer #(
   parameter int numInput   = 10,
   parameter int inputWidth = 16,
   parameter int cntWidth   = $clog2(numInput + 1)
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [inputWidth-1:0]          i_data,
   input  logic                           i_valid,
   output logic                           o_ready,
   input  logic                           i_flush,
   input  logic                           i_ds_done,
   output logic [numInput*inputWidth-1:0] o_data,
   output logic                           o_data_valid,
   output logic [cntWidth-1:0]            o_count
);

   typedef enum logic [1:0] {FILL, EMIT, WAIT_DS} state_t;

   localparam logic [cntWidth-1:0] LastIdx = cntWidth'(numInput - 1);

   state_t                           state_q, state_d;
   logic [cntWidth-1:0]              count_q, count_d;
   logic [numInput*inputWidth-1:0]   stage_q, stage_d;
   logic [numInput*inputWidth-1:0]   data_q,  data_d;
   logic                             valid_q, valid_d;
   logic                             ready_q, ready_d;
   logic [inputWidth-1:0]            word;
   logic                             accept;

   // Word as it will be stored: raw bits, or negatives clamped to zero
   always_comb begin
`ifdef PACKER_RELU_EN
      word = i_data[inputWidth-1] ? '0 : i_data;
`else
      word = i_data;
`endif
   end

   // Next-state logic; flush overrides everything and drops the presented word
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      stage_d = stage_q;
      data_d  = data_q;
      valid_d = 1'b0;
      accept  = i_valid && ready_q && !i_flush && (state_q == FILL);
      if (i_flush) begin
         state_d = FILL;
         count_d = '0;
      end else begin
         case (state_q)
            FILL: begin
               if (accept) begin
                  for (int k = 0; k < numInput; k++) begin
                     if (count_q == cntWidth'(k)) begin
                        stage_d[k*inputWidth +: inputWidth] = word;
                     end
                  end
                  count_d = count_q + 1'b1;
                  if (count_q == LastIdx) begin
                     state_d = EMIT;
                  end
               end
            end
            EMIT: begin
               data_d  = stage_q;
               valid_d = 1'b1;
               count_d = '0;
               state_d = WAIT_DS;
            end
            WAIT_DS: begin
               // A done seen alongside our own pulse cannot belong to this vector
               if (i_ds_done && !valid_q) begin
                  state_d = FILL;
               end
            end
            default: begin
               state_d = FILL;
               count_d = '0;
            end
         endcase
      end
      ready_d = (state_d == FILL) && !i_flush;
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= FILL;
         count_q <= '0;
         stage_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         stage_q <= stage_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
      end
   end

   assign o_ready      = ready_q;
   assign o_data       = data_q;
   assign o_data_valid = valid_q;
   assign o_count      = count_q;

endmodule

// File: tb/tb_layer_output_packer.sv
// Self-checking bench for layer_output_packer (numInput=10, inputWidth=16).
// Reference model: a queue of accepted words plus "vector complete" and
// "waiting for downstream" flags, stepped once per clock edge.
module tb_layer_output_packer;

   localparam int N  = 10;
   localparam int W  = 16;
   localparam int CW = $clog2(N + 1);

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [W-1:0]   i_data = '0;
   logic           i_valid = 1'b0;
   logic           i_flush = 1'b0;
   logic           i_ds_done = 1'b0;
   logic           o_ready;
   logic [N*W-1:0] o_data;
   logic           o_data_valid;
   logic [CW-1:0]  o_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   layer_output_packer #(.numInput(N), .inputWidth(W)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_data       (i_data),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_flush      (i_flush),
      .i_ds_done    (i_ds_done),
      .o_data       (o_data),
      .o_data_valid (o_data_valid),
      .o_count      (o_count)
   );

   // ---------------- reference model ----------------
   bit           m_ready, m_valid, m_emit, m_wait;
   logic [N*W-1:0] m_data;
   logic [W-1:0] q[$];

   function automatic logic [W-1:0] clamp(input logic [W-1:0] d);
`ifdef PACKER_RELU_EN
      return d[W-1] ? '0 : d;
`else
      return d;
`endif
   endfunction

   task automatic model_reset();
      m_ready = 0; m_valid = 0; m_emit = 0; m_wait = 0;
      m_data = '0;
      q.delete();
   endtask

   task automatic model_step(input bit v, input logic [W-1:0] d, input bit fl, input bit dd);
      bit nv;
      nv = 0;
      if (fl) begin
         q.delete();
         m_emit = 0; m_wait = 0; m_ready = 0;
      end else if (m_emit) begin
         for (int k = 0; k < N; k++) m_data[k*W +: W] = q[k];
         nv = 1;
         q.delete();
         m_emit = 0; m_wait = 1; m_ready = 0;
      end else if (m_wait) begin
         if (dd && !m_valid) m_wait = 0;
         m_ready = !m_wait;
      end else begin
         if (v && m_ready) begin
            q.push_back(clamp(d));
            if (q.size() == N) m_emit = 1;
         end
         m_ready = !m_emit;
      end
      m_valid = nv;
   endtask

   function automatic logic [2+CW+N*W-1:0] exp_all();
      return {m_ready, m_valid, CW'(q.size()), m_data};
   endfunction

   function automatic logic [N*W-1:0] pack(input logic [W-1:0] w [N]);
      logic [N*W-1:0] r;
      for (int k = 0; k < N; k++) r[k*W +: W] = clamp(w[k]);
      return r;
   endfunction

   // One clock: apply inputs, step model at the edge, sample 1 time unit later
   task automatic tick(input bit v, input logic [W-1:0] d, input bit fl, input bit dd);
      i_valid = v; i_data = d; i_flush = fl; i_ds_done = dd;
      @(posedge clk);
      model_step(v, d, fl, dd);
      #1;
   endtask

   // Streams N words (continuous or every other cycle); returns what it saw
   task automatic run_vector(input logic [W-1:0] words [N], input bit gapped,
                             output int pulses, output logic [N*W-1:0] cap, output int bad);
      int idx, tail;
      bit v, acc;
      idx = 0; tail = 0; pulses = 0; bad = 0; cap = '0;
      for (int c = 0; c < 80 && tail < 3; c++) begin
         v   = (gapped ? (c % 2 == 0) : 1'b1) && (idx < N);
         acc = v && m_ready;
         tick(v, (idx < N) ? words[idx] : W'(0), 1'b0, m_valid);
         if (acc) idx++;
         if ({o_ready, o_data_valid, o_count, o_data} !== exp_all()) bad++;
         if (o_data_valid) begin pulses++; cap = o_data; end
         if (pulses > 0) tail++;
      end
   endtask

   task automatic release_ds();
      for (int c = 0; c < 5 && !m_ready; c++) tick(1'b0, '0, 1'b0, 1'b1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      model_reset();
      #1;
      if ({o_ready, o_data_valid, o_count, o_data} !== '0) begin
         errors++; $display("FAIL reset_state got %h required 0", {o_ready, o_data_valid, o_count, o_data});
      end
      checks++;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      if (o_ready !== 1'b0) begin errors++; $display("FAIL ready_at_release got %b required 0", o_ready); end
      checks++;
      tick(1'b0, '0, 1'b0, 1'b0);
      if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_rise got %b required 1", o_ready); end
      checks++;
   endtask

   task automatic test_stream();
      logic [W-1:0] w [N];
      logic [N*W-1:0] cap, expv;
      int pulses, bad;
      for (int k = 0; k < N; k++) begin w[k] = W'(k + 1); expv[k*W +: W] = W'(k + 1); end
      run_vector(w, 1'b0, pulses, cap, bad);
      if (bad !== 0) begin errors++; $display("FAIL stream_cycles got %0d bad cycles required 0", bad); end
      checks++;
      if (pulses !== 1) begin errors++; $display("FAIL stream_pulses got %0d required 1", pulses); end
      checks++;
      if (cap !== expv) begin errors++; $display("FAIL stream_data got %h required %h", cap, expv); end
      checks++;
      if (o_ready !== 1'b0) begin errors++; $display("FAIL stream_ready_held got %b required 0", o_ready); end
      checks++;
   endtask

   task automatic test_stall();
      logic [N*W-1:0] held;
      held = o_data;
      for (int c = 0; c < 20; c++) begin
         tick(1'b1, W'($urandom), 1'b0, 1'b0);
         if (o_count !== '0 || o_ready !== 1'b0 || o_data !== held) begin
            errors++; $display("FAIL stall_c%0d got cnt=%0d rdy=%b data=%h required cnt=0 rdy=0 data=%h",
                               c, o_count, o_ready, o_data, held);
         end
         checks++;
      end
      tick(1'b0, '0, 1'b0, 1'b1);
      if (o_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b required 1", o_ready); end
      checks++;
   endtask

   task automatic test_gapped();
      logic [W-1:0] w [N];
      logic [N*W-1:0] cap;
      int pulses, bad;
      for (int k = 0; k < N; k++) w[k] = W'($urandom);
      run_vector(w, 1'b1, pulses, cap, bad);
      if (bad !== 0) begin errors++; $display("FAIL gapped_cycles got %0d bad cycles required 0", bad); end
      checks++;
      if (pulses !== 1 || cap !== pack(w)) begin
         errors++; $display("FAIL gapped_data got %0d pulses data %h required 1 pulse data %h", pulses, cap, pack(w));
      end
      checks++;
      release_ds();
   endtask

   task automatic test_flush();
      logic [W-1:0] w [N];
      logic [N*W-1:0] cap;
      int pulses, bad;
      for (int k = 0; k < 4; k++) tick(1'b1, W'($urandom), 1'b0, 1'b0);
      if (o_count !== CW'(4)) begin errors++; $display("FAIL flush_pre got %0d required 4", o_count); end
      checks++;
      tick(1'b1, 16'h5555, 1'b1, 1'b0);
      if (o_count !== '0 || o_ready !== 1'b0) begin
         errors++; $display("FAIL flush_clear got cnt=%0d rdy=%b required cnt=0 rdy=0", o_count, o_ready);
      end
      checks++;
      for (int k = 0; k < N; k++) w[k] = W'($urandom);
      run_vector(w, 1'b0, pulses, cap, bad);
      if (bad !== 0 || pulses !== 1 || cap !== pack(w)) begin
         errors++; $display("FAIL flush_vector got bad=%0d pulses=%0d data=%h required 0/1/%h", bad, pulses, cap, pack(w));
      end
      checks++;
      release_ds();
   endtask

   task automatic test_flush_emit();
      logic [N*W-1:0] held;
      held = o_data;
      for (int c = 0; c < 30 && !m_emit; c++) tick(1'b1, W'($urandom), 1'b0, 1'b0);
      if (!m_emit) begin errors++; $display("FAIL flush_emit_reach got no EMIT required EMIT"); end
      checks++;
      tick(1'b0, '0, 1'b1, 1'b0);
      if (o_data_valid !== 1'b0 || o_data !== held || o_count !== '0 || o_ready !== 1'b0) begin
         errors++; $display("FAIL flush_emit got vld=%b cnt=%0d rdy=%b data=%h required 0/0/0/%h",
                            o_data_valid, o_count, o_ready, o_data, held);
      end
      checks++;
      tick(1'b0, '0, 1'b0, 1'b0);
      if (o_ready !== 1'b1 || o_data_valid !== 1'b0) begin
         errors++; $display("FAIL flush_emit_after got rdy=%b vld=%b required 1/0", o_ready, o_data_valid);
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] w [N];
      logic [N*W-1:0] cap;
      int pulses, bad;
      for (int k = 0; k < 7; k++) tick(1'b1, W'($urandom), 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      if ({o_ready, o_data_valid, o_count, o_data} !== '0) begin
         errors++; $display("FAIL async_reset got %h required 0", {o_ready, o_data_valid, o_count, o_data});
      end
      checks++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < N; k++) w[k] = W'($urandom);
      run_vector(w, 1'b0, pulses, cap, bad);
      if (bad !== 0 || pulses !== 1 || cap !== pack(w)) begin
         errors++; $display("FAIL reset_mid_vector got bad=%0d pulses=%0d data=%h required 0/1/%h", bad, pulses, cap, pack(w));
      end
      checks++;
      release_ds();
   endtask

   task automatic test_relu();
      logic [W-1:0] w [N];
      logic [N*W-1:0] cap, expv;
      int pulses, bad;
      for (int k = 0; k < N; k++) begin w[k] = 16'h0001; expv[k*W +: W] = 16'h0001; end
      w[0] = 16'hFFFF; w[1] = 16'h8000; w[2] = 16'h7FFF;
`ifdef PACKER_RELU_EN
      expv[0*W +: W] = 16'h0000; expv[1*W +: W] = 16'h0000;
`else
      expv[0*W +: W] = 16'hFFFF; expv[1*W +: W] = 16'h8000;
`endif
      expv[2*W +: W] = 16'h7FFF;
      run_vector(w, 1'b0, pulses, cap, bad);
      if (pulses !== 1 || cap !== expv) begin
         errors++; $display("FAIL relu_data got %0d pulses data %h required 1 pulse data %h", pulses, cap, expv);
      end
      checks++;
      release_ds();
   endtask

   task automatic test_back_to_back();
      bit v, fl, dd;
      for (int c = 0; c < 400; c++) begin
         v  = ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 39) == 0);
         dd = ($urandom_range(0, 2) == 0);
         tick(v, W'($urandom), fl, dd);
         if ({o_ready, o_data_valid, o_count, o_data} !== exp_all()) begin
            errors++; $display("FAIL random_c%0d got %h required %h", c, {o_ready, o_data_valid, o_count, o_data}, exp_all());
         end
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_gapped();
      test_flush();
      test_flush_emit();
      test_reset_mid();
      test_relu();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
